// File: rtl/write_arbiter_pkg.sv
// Shared constants and FSM state type for the write arbiter.
//   NUM_OF_PORTS : default number of requesting ports
//   LEN_WIDTH    : default width of each packet-length field (beats)
//   SEL_WIDTH    : width of the channel-selector index
//   state_t      : arbiter FSM states
package write_arbiter_pkg;

  localparam int unsigned NUM_OF_PORTS = 16;
  localparam int unsigned LEN_WIDTH    = 6;
  localparam int unsigned SEL_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted request searching upward
// from ptr with wrap-around.
//   req    : per-port request vector
//   ptr    : port index where the search starts
//   winner : index of the first asserted request at or after ptr
//   found  : any request asserted
module rr_pick
  import write_arbiter_pkg::*;
#(
  parameter int unsigned num_of_ports = NUM_OF_PORTS,
  parameter int unsigned idx_width    = (num_of_ports > 1) ? $clog2(num_of_ports) : 1
) (
  input  logic [num_of_ports-1:0] req,
  input  logic [idx_width-1:0]    ptr,
  output logic [idx_width-1:0]    winner,
  output logic                    found
);

  always_comb begin
    logic [idx_width:0]   sum;
    logic [idx_width-1:0] idx;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < num_of_ports; k++) begin
      // ptr + k stays below 2*num_of_ports, so a single subtraction wraps it
      sum = {1'b0, ptr} + (idx_width+1)'(k);
      if (sum >= (idx_width+1)'(num_of_ports)) begin
        sum = sum - (idx_width+1)'(num_of_ports);
      end
      idx = sum[idx_width-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/write_arbiter_ctrl.sv
// Write arbiter: grants one requesting port at a time in round-robin order,
// streams that port's packet one beat per sram_ready, then inserts a
// one-cycle gap so the channel selector can release its destination lock.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-port write request (level)
//   pkt_len    : packed per-port packet length in beats (0 means 1 beat)
//   sram_ready : downstream accepts one beat this cycle
//   select     : granted port index to the channel selector
//   enable     : channel selector enable, high while a packet transfers
//   grant      : one-hot grant, held for the whole packet
//   beat_ack   : one beat consumed this cycle
//   pkt_done   : one-cycle pulse after the last beat
//   busy       : arbiter not idle
module write_arbiter_ctrl
  import write_arbiter_pkg::*;
#(
  parameter int unsigned num_of_ports = NUM_OF_PORTS,
  parameter int unsigned len_width    = LEN_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_of_ports-1:0]           req,
  input  logic [len_width*num_of_ports-1:0] pkt_len,
  input  logic                              sram_ready,
  output logic [SEL_WIDTH-1:0]              select,
  output logic                              enable,
  output logic [num_of_ports-1:0]           grant,
  output logic                              beat_ack,
  output logic                              pkt_done,
  output logic                              busy
);

  localparam int unsigned IDX_W = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic [len_width-1:0]    remaining;
  logic [len_width-1:0]    load_len;
  logic [SEL_WIDTH-1:0]    select_q;
  logic [num_of_ports-1:0] grant_q;
  logic [num_of_ports-1:0] win_onehot;
  logic                    start;
  logic [len_width-1:0]    lens [num_of_ports];

  for (genvar p = 0; p < num_of_ports; p++) begin : g_lens
    assign lens[p] = pkt_len[p*len_width +: len_width];
  end

  rr_pick #(
    .num_of_ports (num_of_ports),
    .idx_width    (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    load_len = (lens[winner] == '0) ? len_width'(1) : lens[winner];
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  assign start = (state == ST_IDLE) && found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enable    = 1'b0;
    beat_ack  = 1'b0;
    pkt_done  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (found) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        enable   = 1'b1;
        beat_ack = sram_ready;
        if (sram_ready && (remaining == len_width'(1))) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        pkt_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: grant/select/length captured at packet start; grant is dropped
  // on the last beat so it is already clear during the gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      select_q  <= '0;
      grant_q   <= '0;
    end else if (start) begin
      select_q  <= SEL_WIDTH'(winner);
      grant_q   <= win_onehot;
      remaining <= load_len;
      ptr       <= (winner == IDX_W'(num_of_ports - 1)) ? '0 : winner + 1'b1;
    end else if (beat_ack) begin
      remaining <= remaining - 1'b1;
      if (remaining == len_width'(1)) grant_q <= '0;
    end
  end

  assign select = select_q;
  assign grant  = grant_q;

endmodule

// File: tb/tb_write_arbiter_ctrl.sv
// Directed self-checking bench for write_arbiter_ctrl.
module tb_write_arbiter_ctrl;

  localparam int unsigned NP = 16;
  localparam int unsigned LW = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [LW*NP-1:0] pkt_len;
  logic             sram_ready;
  logic [3:0]       select;
  logic             enable;
  logic [NP-1:0]    grant;
  logic             beat_ack;
  logic             pkt_done;
  logic             busy;

  int checks = 0;
  int errors = 0;

  write_arbiter_ctrl #(
    .num_of_ports (NP),
    .len_width    (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pkt_len    (pkt_len),
    .sram_ready (sram_ready),
    .select     (select),
    .enable     (enable),
    .grant      (grant),
    .beat_ack   (beat_ack),
    .pkt_done   (pkt_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_len(input int p, input int v);
    pkt_len[p*LW +: LW] = LW'(v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Runs one packet already requested: cycle c drives sram_ready = !stall[c],
  // drops req and scrambles pkt_len after the first cycle, and stops on pkt_done.
  task automatic scan(input logic [15:0] stall, output int en_cyc, output int acks,
                      output logic done_seen, output logic [15:0] g_first,
                      output logic [3:0] s_first);
    en_cyc    = 0;
    acks      = 0;
    done_seen = 1'b0;
    g_first   = '0;
    s_first   = '0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      sram_ready = (c < 16) ? !stall[c] : 1'b1;
      #1;
      if (enable)   en_cyc++;
      if (beat_ack) acks++;
      if (c == 1) begin
        g_first = grant;
        s_first = select;
        req     = '0;
        pkt_len = '1;
      end
      if (pkt_done) done_seen = 1'b1;
    end
    sram_ready = 1'b1;
  endtask

  initial begin
    int         en_c, ack_c, cyc, last, pd, bz;
    logic       dn, seen;
    logic [15:0] gf;
    logic [3:0]  sf;

    rst        = 1'b1;
    req        = '0;
    pkt_len    = '0;
    sram_ready = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_select",   32'(select),   32'd0);
    check("rst_enable",   32'(enable),   32'd0);
    check("rst_grant",    32'(grant),    32'd0);
    check("rst_beat_ack", 32'(beat_ack), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    rst = 1'b0;

    // single requester, 3 beats on port 2
    req = 16'h0004;
    set_len(2, 3);
    scan(16'h0000, en_c, ack_c, dn, gf, sf);
    check("single_grant",  32'(gf),    32'h0004);
    check("single_select", 32'(sf),    32'd2);
    check("single_en_cyc", 32'(en_c),  32'd3);
    check("single_acks",   32'(ack_c), 32'd3);
    check("single_done",   32'(dn),    32'd1);
    check("single_gap_grant",  32'(grant),  32'd0);
    check("single_gap_enable", 32'(enable), 32'd0);
    check("single_gap_busy",   32'(busy),   32'd1);
    @(negedge clk);
    check("single_done_pulse", 32'(pkt_done), 32'd0);
    check("single_busy_low",   32'(busy),     32'd0);
    check("single_sel_hold",   32'(select),   32'd2);

    // round robin, all ports requesting with 1-beat packets
    apply_reset();
    pkt_len = '0;
    for (int p = 0; p < 16; p++) set_len(p, 1);
    req  = 16'hFFFF;
    cyc  = 0;
    last = 0;
    for (int g = 0; g <= 16; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        @(negedge clk);
        cyc++;
        if (grant != '0) seen = 1'b1;
      end
      check("rr_grant", 32'(grant), 32'd1 << (g % 16));
      if (g > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    req = '0;
    wait_idle("rr_idle");

    // zero length and pointer wrap: park ptr at 15 via a grant on port 14
    apply_reset();
    pkt_len = '0;
    req = 16'h4000;
    set_len(14, 1);
    scan(16'h0000, en_c, ack_c, dn, gf, sf);
    check("wrap_pre_grant", 32'(gf), 32'h4000);
    @(negedge clk);
    req = 16'h8001;
    pkt_len = '0;
    set_len(0, 2);
    @(negedge clk);
    check("wrap_grant15",  32'(grant),  32'h8000);
    check("wrap_sel15",    32'(select), 32'd15);
    check("wrap_en15",     32'(enable), 32'd1);
    @(negedge clk);
    check("wrap_zero_len_done", 32'(pkt_done), 32'd1);
    check("wrap_zero_len_en",   32'(enable),   32'd0);
    @(negedge clk);
    check("wrap_idle_sel", 32'(select), 32'd15);
    @(negedge clk);
    check("wrap_grant0", 32'(grant),  32'h0001);
    check("wrap_sel0",   32'(select), 32'd0);
    req = '0;
    wait_idle("wrap_idle");

    // reset in the middle of a 5-beat packet on port 9
    req = 16'h0200;
    pkt_len = '0;
    set_len(9, 5);
    @(negedge clk);
    check("abort_grant", 32'(grant), 32'h0200);
    req = '0;
    @(negedge clk);
    check("abort_beat2", 32'(enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_select",   32'(select),   32'd0);
    check("abort_enable",   32'(enable),   32'd0);
    check("abort_grant0",   32'(grant),    32'd0);
    check("abort_beat_ack", 32'(beat_ack), 32'd0);
    check("abort_pkt_done", 32'(pkt_done), 32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    pd = 0;
    bz = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pkt_done) pd++;
      if (busy) bz++;
    end
    check("abort_no_done", 32'(pd), 32'd0);
    check("abort_no_busy", 32'(bz), 32'd0);
    req = 16'h0401;
    set_len(0, 1);
    set_len(10, 1);
    @(negedge clk);
    check("abort_search_from0", 32'(grant), 32'h0001);
    req = '0;
    wait_idle("abort_idle");

    // backpressure: 4 beats, sram_ready low in beat cycles 2 and 3
    req = 16'h0080;
    pkt_len = '0;
    set_len(7, 4);
    scan(16'h000C, en_c, ack_c, dn, gf, sf);
    check("bp_grant",  32'(gf),    32'h0080);
    check("bp_en_cyc", 32'(en_c),  32'd6);
    check("bp_acks",   32'(ack_c), 32'd4);
    check("bp_done",   32'(dn),    32'd1);
    wait_idle("bp_idle");

    // request withdrawn and length changed right after grant on port 5
    req = 16'h0020;
    pkt_len = '0;
    set_len(5, 3);
    scan(16'h0000, en_c, ack_c, dn, gf, sf);
    check("wd_grant",  32'(gf),    32'h0020);
    check("wd_select", 32'(sf),    32'd5);
    check("wd_en_cyc", 32'(en_c),  32'd3);
    check("wd_acks",   32'(ack_c), 32'd3);
    check("wd_done",   32'(dn),    32'd1);
    wait_idle("wd_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_arbiter_ctrl.md
WRITE_ARBITER_CTRL -- requirements
Module: write_arbiter_ctrl

Interface
REQ-001 SHALL have parameter num_of_ports, default 16: number of requesting input ports.
REQ-002 SHALL have parameter len_width, default 6: width of each packet-length field, in beats.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, num_of_ports: per-port write request, level.
REQ-006 SHALL have port pkt_len, input, len_width*num_of_ports: packed per-port packet length; field i is bits [(i+1)*len_width-1 : i*len_width].
REQ-007 SHALL have port sram_ready, input, 1: downstream accepts one beat this cycle.
REQ-008 SHALL have port select, output, 4: index of the granted port, driven to the channel selector.
REQ-009 SHALL have port enable, output, 1: channel selector enable; high only while a packet is transferring.
REQ-010 SHALL have port grant, output, num_of_ports: one-hot grant to the owning requester, held for the whole packet.
REQ-011 SHALL have port beat_ack, output, 1: high in each BUSY cycle where sram_ready=1, meaning one beat is consumed.
REQ-012 SHALL have port pkt_done, output, 1: one-cycle pulse in the cycle after the last beat is consumed.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and GAP.
REQ-015 IDLE SHALL go to BUSY on the next edge when |req=1; otherwise it SHALL stay in IDLE.
REQ-016 On the IDLE->BUSY edge the block SHALL register select=winner, grant=1<<winner and remaining=pkt_len[winner], and SHALL set ptr=(winner+1) mod num_of_ports.
REQ-017 The winner SHALL be the first asserted req found searching upward from ptr with wrap-around (round-robin).
REQ-018 A pkt_len of 0 SHALL be treated as 1 beat.
REQ-019 BUSY SHALL drive enable=1 and beat_ack=sram_ready, and SHALL decrement remaining on each beat_ack.
REQ-020 When sram_ready=0 in BUSY, the counter and the state SHALL hold.
REQ-021 BUSY SHALL go to GAP on the edge where remaining=1 and sram_ready=1.
REQ-022 GAP SHALL last exactly one cycle with enable=0, grant=0 and pkt_done=1, then go to IDLE; this idle cycle releases the channel selector's destination-port lock.
REQ-023 Latency SHALL be: req sampled in IDLE at edge N gives enable=1 from N+1; an L-beat packet with sram_ready held high gives enable high for exactly L cycles.
REQ-024 Deasserting req or changing pkt_len during BUSY SHALL have no effect; the packet completes.
REQ-025 ptr SHALL advance only on a grant and SHALL wrap from num_of_ports-1 to 0.
REQ-026 Minimum spacing between packets SHALL be 2 idle-enable cycles (GAP + IDLE).
REQ-027 grant SHALL never have more than one bit set.
REQ-028 select SHALL hold its value through GAP and IDLE and change only on a new grant.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, ptr=0, remaining=0, select=0, enable=0, grant=0, beat_ack=0, pkt_done=0 and busy=0, including in the middle of a packet.
REQ-030 An aborted packet SHALL NOT produce pkt_done.
REQ-031 After rst deasserts, the first arbitration SHALL start its search from port 0.

Structure
REQ-032 The FSM state encodings and the default num_of_ports and len_width constants SHALL live in the shared package write_arbiter_pkg.
REQ-033 The round-robin search SHALL be a separate combinational sub-module, rr_pick: inputs req and ptr; outputs winner and found.
REQ-034 The outputs select and enable SHALL connect directly to the channel selector's select and enable inputs.

Verification
REQ-035 Bench SHALL cover single requester: req=0x0004, len[2]=3, sram_ready=1 -> enable high 3 cycles, select=2, grant=0x0004, then pkt_done pulse, busy low 2 cycles later.
REQ-036 Bench SHALL cover round-robin: req=0xFFFF held, all len=1 -> grant sequence ports 0,1,2,...,15,0, with a grant every 3 cycles.
REQ-037 Bench SHALL cover backpressure: len=4, sram_ready low in beat cycles 2-3 -> enable high 6 cycles, exactly 4 beat_ack pulses.
REQ-038 Bench SHALL cover zero length and wrap: ptr=15, req=0x8001, len[15]=0 -> port 15 granted for 1 beat, then port 0 granted next.
REQ-039 Bench SHALL cover reset mid-packet: rst pulsed at beat 2 of 5 -> all outputs 0 asynchronously, no pkt_done, next grant searches from port 0.
REQ-040 Bench SHALL cover request withdrawal: req[5] dropped after grant, len=3 -> packet still completes with 3 beats.
